// File: rtl/modulate_pkg.sv
// rtl/modulate_pkg.sv - shared types and constants for the FM modulator
package modulate_pkg;

  localparam int FRAC_BITS  = 10;
  // Extra fraction bits carried by the CORDIC x/y path below the Q10 point.
  localparam int GUARD_BITS = 10;
  localparam logic signed [31:0] CORDIC_K = 32'sd622;

  typedef enum logic [1:0] {IDLE, PREP, ROTATE, EMIT} state_t;

  // atan(2^-i) in turns, 2^32 = one full revolution
  localparam logic [31:0] ATAN [0:15] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D
  };

endpackage

// File: rtl/modulate_cordic_rotate.sv
// rtl/modulate_cordic_rotate.sv - iterative CORDIC rotation with quadrant fold and fix-up
module cordic_rotate
  import modulate_pkg::*;
#(
  parameter int ITERS     = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          phase,
  output logic                 done,
  output logic [OUT_WIDTH-1:0] real_out,
  output logic [OUT_WIDTH-1:0] imag_out
);

  localparam int IW = $clog2(ITERS);
  localparam logic signed [31:0] X_INIT = CORDIC_K <<< GUARD_BITS;
  localparam logic signed [31:0] HALF   = 32'sd1 <<< (GUARD_BITS - 1);

  logic signed [31:0] x, y, z;
  logic signed [31:0] x_shift, y_shift, x_next, y_next, z_next, x_round, y_round;
  logic [IW-1:0]      i;
  logic               busy, neg, z_pos, fold;

  assign fold = phase[31] ^ phase[30];
  assign done = busy && (i == IW'(ITERS - 1));

  always_comb begin
    x_shift = x >>> i;
    y_shift = y >>> i;
    z_pos   = !z[31];
    x_next  = z_pos ? x - y_shift : x + y_shift;
    y_next  = z_pos ? y + x_shift : y - x_shift;
    z_next  = z_pos ? z - $signed(ATAN[i]) : z + $signed(ATAN[i]);
    x_round = (x_next + HALF) >>> GUARD_BITS;
    y_round = (y_next + HALF) >>> GUARD_BITS;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x        <= '0;
      y        <= '0;
      z        <= '0;
      i        <= '0;
      busy     <= 1'b0;
      neg      <= 1'b0;
      real_out <= '0;
      imag_out <= '0;
    end else if (start) begin
      // Fold the left half-plane onto the right; the result is negated at the end.
      neg  <= fold;
      z    <= fold ? (phase ^ 32'h8000_0000) : phase;
      x    <= X_INIT;
      y    <= '0;
      i    <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      x <= x_next;
      y <= y_next;
      z <= z_next;
      i <= i + IW'(1);
      if (done) begin
        busy     <= 1'b0;
        real_out <= OUT_WIDTH'(neg ? -x_round : x_round);
        imag_out <= OUT_WIDTH'(neg ? -y_round : y_round);
      end
    end
  end

endmodule

// File: rtl/modulate.sv
// rtl/modulate.sv - FM modulator: audio FIFO -> phase accumulator -> CORDIC -> I/Q FIFOs
module modulate
  import modulate_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CORDIC_ITERS = 16,
  parameter int GAIN         = 1048576
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] audio_in,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [DATA_WIDTH-1:0] real_out,
  output logic [DATA_WIDTH-1:0] imag_out
);

  state_t      state, state_next;
  logic [31:0] phase, phase_inc;
  logic        cordic_start, cordic_done;

  // Low 32 bits of the product are the same for signed and unsigned operands.
  assign phase_inc = 32'(audio_in) * 32'(GAIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      phase <= '0;
    end else begin
      state <= state_next;
      if (in_rd_en) phase <= phase + phase_inc;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!in_empty) state_next = PREP;
      PREP:    state_next = ROTATE;
      ROTATE:  if (cordic_done) state_next = EMIT;
      EMIT:    if (!out_full) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_rd_en     = 1'b0;
    out_wr_en    = 1'b0;
    cordic_start = 1'b0;
    case (state)
      IDLE:    in_rd_en = reset && !in_empty;
      PREP:    cordic_start = 1'b1;
      EMIT:    out_wr_en = reset && !out_full;
      default: ;
    endcase
  end

  cordic_rotate #(
    .ITERS     (CORDIC_ITERS),
    .OUT_WIDTH (DATA_WIDTH)
  ) u_cordic (
    .clk      (clk),
    .reset    (reset),
    .start    (cordic_start),
    .phase    (phase),
    .done     (cordic_done),
    .real_out (real_out),
    .imag_out (imag_out)
  );

endmodule

// File: doc/modulate.md
# modulate

FM modulator: the transmit-side counterpart of the demodulator. Pops signed fixed-point audio samples from an upstream first-word-fall-through FIFO, integrates them into a phase accumulator, and computes cos/sin of that phase with an iterative CORDIC. Each result is written as a real/imag I/Q pair into downstream output FIFOs, so a modulate→demodulate loopback recovers the audio.

## Interface
- DATA_WIDTH, 32: audio and I/Q sample width, signed two's complement.
- FRAC_BITS, 10: fractional bits; 1.0 = 2^FRAC_BITS = 1024.
- CORDIC_ITERS, 16: CORDIC micro-rotations, one per cycle.
- GAIN, 1048576: phase increment per unit audio LSB; 1.0 full-scale audio gives 2^30 (π/2) per sample.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- audio_in  in  DATA_WIDTH  upstream FIFO dout; valid whenever in_empty=0.
- in_empty  in  1  upstream FIFO empty.
- in_rd_en  out  1  pops upstream FIFO.
- out_full  in  1  OR of real/imag output FIFO full flags.
- out_wr_en  out  1  writes real_out/imag_out to both output FIFOs.
- real_out  out  DATA_WIDTH  cos component, Q(FRAC_BITS).
- imag_out  out  DATA_WIDTH  sin component, Q(FRAC_BITS).

## Operation
- Phase accumulator: 32-bit unsigned, full scale = 2π, wraps modulo 2^32. Update: phase += low 32 bits of signed product audio_in × GAIN.
- States:
  - IDLE: in_rd_en = !in_empty. On pop, sample is consumed and phase is updated on the same edge; go to PREP.
  - PREP: quadrant fold. If phase[31:30] is 01 or 10, z = phase ^ 0x8000_0000 and set neg=1; else z = phase and neg=0. Treat z as signed with |z| ≤ π/2. Init x = CORDIC_K, y = 0, i = 0. Go to ROTATE.
  - ROTATE: for CORDIC_ITERS cycles, d = sign(z):
    - x' = x − d·(y>>>i)
    - y' = y + d·(x>>>i)
    - z' = z − d·ATAN[i]
    - i++
    - After the last iteration, load real_out/imag_out with x,y, both negated if neg. Go to EMIT.
  - EMIT: out_wr_en = !out_full. On write, go to IDLE. While out_full, hold the state and the data.
- Arithmetic:
  - x, y are 32-bit signed; shifts are arithmetic.
  - z and ATAN are 32-bit turn-scaled (2^32 = 2π).
  - CORDIC_K = round(0.6072529 × 2^FRAC_BITS) = 622. Output magnitude is 1024 ±2 LSB.
- Reset (async, any state):
  - state=IDLE, phase=0, neg=0, x=y=z=i=0.
  - real_out = imag_out = 0, out_wr_en = 0.
  - in_rd_en is forced 0 while reset is low.
  - The in-flight sample is discarded and never emitted.
- No input is popped while a sample is in PREP, ROTATE or EMIT, so there is exactly one sample in flight.

## Timing
- Pop edge at cycle t: PREP occupies t+1; ROTATE occupies t+2..t+1+CORDIC_ITERS; out_wr_en is high in cycle t+2+CORDIC_ITERS = t+18 if out_full=0.
- Earliest next pop is cycle t+19. Sustained throughput is 1 sample / (CORDIC_ITERS+3) cycles.
- in_rd_en and out_wr_en are combinational from registered state and the FIFO flags. real_out/imag_out are registered and stable throughout EMIT.
- in_rd_en and out_wr_en are never high in the same cycle.

## Structure
- Package modulate_pkg holds:
  - state enum {IDLE, PREP, ROTATE, EMIT}
  - CORDIC_K
  - ATAN[0:15] = round(atan(2^-i) × 2^32 / 2π); ATAN[0] = 0x2000_0000
- One sub-module, cordic_rotate: the iterative x/y/z datapath with i counter, start/done, and the neg fix-up. The modulate module keeps the FSM, phase accumulator and FIFO handshakes.
- Top-level integration instantiates the codebase fifo for the input and the two output FIFOs, mirroring the demodulator top.

## Test plan
- Zero audio: four samples of 0 → four writes of (1024, 0) ±2; phase stays 0.
- Audio 1024 ×4 → (0, 1024), (−1024, 0), (0, −1024), (1024, 0) ±2; phase returns to 0 via wrap.
- Audio −1024 then 512 → (0, −1024), then (724, −724) ±2, i.e. phase −π/4.
- Backpressure: out_full held for 30 cycles on entry to EMIT → out_wr_en stays 0, real/imag held, no in_rd_en; exactly one write in the cycle out_full drops.
- Reset pulsed low mid-ROTATE → all outputs 0 immediately, no write for that sample; next sample 0 → (1024, 0), proving phase was cleared.
- Continuous non-empty input → in_rd_en pulses every 19 cycles, each out_wr_en exactly 18 cycles after its pop; output matches a double-precision cos/sin model ±2 LSB over 1000 random samples.
